// File: rtl/sevenseg_scan_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : sevenseg_scan_decoder_if
// Purpose  : Scanned seven-segment bus plus recovered digit outputs.
// Revision : 1.0  initial release
// ============================================================================
interface sevenseg_scan_decoder_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [NUM_DIGITS-1:0]   anodes;
    logic [6:0]              seven_segment;
    logic [4*NUM_DIGITS-1:0] digit_values;
    logic [NUM_DIGITS-1:0]   digit_valid;
    logic                    update;
    logic [IDX_W-1:0]        update_idx;
    logic                    decode_err;

    modport master (
        output anodes, seven_segment,
        input  digit_values, digit_valid, update, update_idx, decode_err
    );

    modport slave (
        input  anodes, seven_segment,
        output digit_values, digit_valid, update, update_idx, decode_err
    );
endinterface
`default_nettype wire

// File: rtl/sevenseg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : sevenseg_scan_decoder
// Purpose  : Recovers hex digits from a multiplexed active-low 7-segment bus.
//            Optional per-digit refresh timeout: SEVENSEG_STALE_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module sevenseg_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int STALE_CYCLES  = 2**20
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    sevenseg_scan_decoder_if.slave  bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam int PAT_W = NUM_DIGITS + 7;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_CAPTURE = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [NUM_DIGITS-1:0]  an_meta, an_sync;
    logic [6:0]             seg_meta, seg_sync;
    logic [PAT_W-1:0]       prev_pat;

    logic [PAT_W-1:0]       pattern;
    logic                   one_low;
    logic [IDX_W-1:0]       cap_idx;
    logic [5:0]             cap_dec;

    // Returns {legal, blank, value}
    function automatic logic [5:0] decode(input logic [6:0] seg);
        logic [5:0] r;
        r = 6'b000000;
        case (seg)
            7'h40: r = {2'b10, 4'h0};
            7'h79: r = {2'b10, 4'h1};
            7'h24: r = {2'b10, 4'h2};
            7'h30: r = {2'b10, 4'h3};
            7'h19: r = {2'b10, 4'h4};
            7'h12: r = {2'b10, 4'h5};
            7'h02: r = {2'b10, 4'h6};
            7'h78: r = {2'b10, 4'h7};
            7'h00: r = {2'b10, 4'h8};
            7'h10: r = {2'b10, 4'h9};
            7'h08: r = {2'b10, 4'hA};
            7'h03: r = {2'b10, 4'hB};
            7'h46: r = {2'b10, 4'hC};
            7'h21: r = {2'b10, 4'hD};
            7'h06: r = {2'b10, 4'hE};
            7'h0E: r = {2'b10, 4'hF};
            7'h7F: r = {2'b01, 4'h0};
            default: r = 6'b000000;
        endcase
        return r;
    endfunction

    function automatic logic [IDX_W-1:0] low_index(input logic [NUM_DIGITS-1:0] an);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    always_comb begin
        pattern = {an_sync, seg_sync};
        one_low = $onehot(~an_sync);
        // prev_pat is frozen during CAPTURE, so it still holds the settled pattern
        cap_idx = low_index(prev_pat[PAT_W-1:7]);
        cap_dec = decode(prev_pat[6:0]);
    end

`ifdef SEVENSEG_STALE_TIMEOUT_EN
    localparam int STL_W = $clog2(STALE_CYCLES + 1);
    logic [STL_W-1:0] stale_cnt [NUM_DIGITS];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_meta           <= '1;
            an_sync           <= '1;
            seg_meta          <= '1;
            seg_sync          <= '1;
            prev_pat          <= '1;
            state             <= S_IDLE;
            cnt               <= '0;
            bus.digit_values  <= '0;
            bus.digit_valid   <= '0;
            bus.update        <= 1'b0;
            bus.update_idx    <= '0;
            bus.decode_err    <= 1'b0;
`ifdef SEVENSEG_STALE_TIMEOUT_EN
            for (int i = 0; i < NUM_DIGITS; i++) stale_cnt[i] <= '0;
`endif
        end else begin
            an_meta        <= bus.anodes;
            an_sync        <= an_meta;
            seg_meta       <= bus.seven_segment;
            seg_sync       <= seg_meta;
            bus.update     <= 1'b0;
            bus.decode_err <= 1'b0;
            if (state != S_CAPTURE) prev_pat <= pattern;

`ifdef SEVENSEG_STALE_TIMEOUT_EN
            // Capture logic below overrides these writes for the same digit
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (stale_cnt[i] >= STL_W'(STALE_CYCLES - 1)) begin
                    stale_cnt[i]       <= STL_W'(STALE_CYCLES);
                    bus.digit_valid[i] <= 1'b0;
                end else begin
                    stale_cnt[i] <= stale_cnt[i] + 1'b1;
                end
            end
`endif

            case (state)
                S_IDLE: begin
                    if (one_low) begin
                        state <= S_SETTLE;
                        cnt   <= CNT_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (pattern == prev_pat) begin
                        if (cnt >= CNT_W'(SETTLE_CYCLES - 1)) begin
                            cnt   <= CNT_W'(SETTLE_CYCLES);
                            state <= S_CAPTURE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (one_low) begin
                        cnt <= CNT_W'(1);
                    end else begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end
                end
                S_CAPTURE: begin
                    bus.update     <= 1'b1;
                    bus.update_idx <= cap_idx;
                    if (cap_dec[5]) begin
                        bus.digit_values[4*cap_idx +: 4] <= cap_dec[3:0];
                        bus.digit_valid[cap_idx]         <= 1'b1;
                    end else begin
                        bus.digit_valid[cap_idx] <= 1'b0;
                        bus.decode_err           <= ~cap_dec[4];
                    end
`ifdef SEVENSEG_STALE_TIMEOUT_EN
                    stale_cnt[cap_idx] <= '0;
`endif
                    state <= S_HOLD;
                end
                S_HOLD: begin
                    if (pattern != prev_pat) begin
                        if (one_low) begin
                            state <= S_SETTLE;
                            cnt   <= CNT_W'(1);
                        end else begin
                            state <= S_IDLE;
                            cnt   <= '0;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire
